// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared CPU types; the ALU operation code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [2:0] {
        Operation_ADD  = 3'd0,
        Operation_SUB  = 3'd1,
        Operation_NOR  = 3'd2,
        Operation_NAND = 3'd3,
        Operation_XOR  = 3'd4,
        Operation_XNOR = 3'd5
    } Operation;

endpackage

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
// Module      : alu_seq
// Description : Runs the 8-bit ALU byte-serially (LSB first) over BYTES-wide
//               operands, chaining carry/borrow and accumulating word flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq #(
    parameter int BYTES = 4
) (
    input  logic                 _iClk,
    input  logic                 _iReset,
    input  logic                 _iStart,
    input  cpu_pkg::Operation    _iOp,
    input  logic [8*BYTES-1:0]   _iA,
    input  logic [8*BYTES-1:0]   _iB,
    input  logic                 _iC,
    output logic                 _oBusy,
    output logic                 _oDone,
    output logic [8*BYTES-1:0]   _oResult,
    output logic                 _oFlagCarry,
    output logic                 _oFlagZero,
    output logic                 _oFlagNeg,
    output logic [7:0]           _oAluA,
    output logic [7:0]           _oAluB,
    output logic                 _oAluC,
    output cpu_pkg::Operation    _oAluOp,
    input  logic [7:0]           _iAluResult,
    input  logic                 _iAluFlagCarry,
    input  logic                 _iAluFlagZero,
    input  logic                 _iAluFlagNeg
);

    import cpu_pkg::*;

    localparam int                IDX_W    = $clog2(BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q,  state_d;
    logic [BYTES-1:0][7:0]   a_q,      a_d;
    logic [BYTES-1:0][7:0]   b_q,      b_d;
    logic [BYTES-1:0][7:0]   result_q, result_d;
    Operation                op_q,     op_d;
    logic [IDX_W-1:0]        idx_q,    idx_d;
    logic                    carry_q,  carry_d;
    logic                    zacc_q,   zacc_d;
    logic                    flag_c_q, flag_c_d;
    logic                    flag_z_q, flag_z_d;
    logic                    flag_n_q, flag_n_d;

    always_ff @(posedge _iClk or posedge _iReset) begin
        if (_iReset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            op_q     <= Operation_ADD;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_n_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
            flag_c_q <= flag_c_d;
            flag_z_q <= flag_z_d;
            flag_n_q <= flag_n_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        op_d     = op_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        flag_c_d = flag_c_q;
        flag_z_d = flag_z_q;
        flag_n_d = flag_n_q;

        _oAluA   = 8'h00;
        _oAluB   = 8'h00;
        _oAluC   = 1'b0;
        _oAluOp  = Operation_ADD;
        _oDone   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (_iStart) begin
                    a_d     = _iA;
                    b_d     = _iB;
                    op_d    = _iOp;
                    carry_d = _iC;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                _oAluA          = a_q[idx_q];
                _oAluB          = b_q[idx_q];
                _oAluC          = carry_q;
                _oAluOp         = op_q;
                result_d[idx_q] = _iAluResult;
                carry_d         = _iAluFlagCarry;
                zacc_d          = zacc_q & _iAluFlagZero;
                // idx parks on the last byte rather than wrapping; start resets it.
                if (idx_q == LAST_IDX) begin
                    flag_c_d = _iAluFlagCarry;
                    flag_n_d = _iAluFlagNeg;
                    flag_z_d = zacc_q & _iAluFlagZero;
                    state_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end

            ST_DONE: begin
                _oDone  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign _oBusy      = (state_q != ST_IDLE);
    assign _oResult    = result_q;
    assign _oFlagCarry = flag_c_q;
    assign _oFlagZero  = flag_z_q;
    assign _oFlagNeg   = flag_n_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (BYTES = 4): directed vector table, randomized operations
// against a word-level model, and hand-written ignore-start / mid-run reset sequences.
`default_nettype none

module tb_alu_seq;
    import cpu_pkg::*;

    localparam int BYTES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    Operation          op_in;
    logic [31:0]       a_in, b_in;
    logic              c_in;
    logic              busy, done;
    logic [31:0]       result;
    logic              f_carry, f_zero, f_neg;
    logic [7:0]        alu_a, alu_b;
    logic              alu_c;
    Operation          alu_op;
    logic [7:0]        alu_res;
    logic              alu_cf, alu_zf, alu_nf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq #(.BYTES(BYTES)) dut (
        ._iClk(clk), ._iReset(rst), ._iStart(start), ._iOp(op_in),
        ._iA(a_in), ._iB(b_in), ._iC(c_in),
        ._oBusy(busy), ._oDone(done), ._oResult(result),
        ._oFlagCarry(f_carry), ._oFlagZero(f_zero), ._oFlagNeg(f_neg),
        ._oAluA(alu_a), ._oAluB(alu_b), ._oAluC(alu_c), ._oAluOp(alu_op),
        ._iAluResult(alu_res), ._iAluFlagCarry(alu_cf),
        ._iAluFlagZero(alu_zf), ._iAluFlagNeg(alu_nf)
    );

    // Combinational 8-bit ALU the sequencer drives.
    logic [8:0] alu_tmp;
    always_comb begin
        alu_tmp = 9'd0;
        case (alu_op)
            Operation_ADD:  alu_tmp = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c};
            Operation_SUB:  alu_tmp = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_c};
            Operation_NOR:  alu_tmp = {1'b0, ~(alu_a | alu_b)};
            Operation_NAND: alu_tmp = {1'b0, ~(alu_a & alu_b)};
            Operation_XOR:  alu_tmp = {1'b0, alu_a ^ alu_b};
            Operation_XNOR: alu_tmp = {1'b0, ~(alu_a ^ alu_b)};
            default:        alu_tmp = 9'd0;
        endcase
        alu_res = alu_tmp[7:0];
        alu_cf  = alu_tmp[8];
        alu_zf  = (alu_tmp[7:0] == 8'd0);
        alu_nf  = alu_tmp[7];
    end

    // Whole-word reference: the result the 32-bit operation should produce.
    function automatic void ref_model(input Operation op, input logic [31:0] a, b,
                                      input logic c, output logic [31:0] r,
                                      output logic cf, zf, nf);
        logic [32:0] s;
        cf = 1'b0;
        case (op)
            Operation_ADD: begin
                s  = {1'b0, a} + {1'b0, b} + {32'd0, c};
                r  = s[31:0];
                cf = s[32];
            end
            Operation_SUB: begin
                r  = a - b - {31'd0, c};
                cf = ({1'b0, a} < ({1'b0, b} + {32'd0, c}));
            end
            Operation_NOR:  r = ~(a | b);
            Operation_NAND: r = ~(a & b);
            Operation_XOR:  r = a ^ b;
            default:        r = ~(a ^ b);
        endcase
        zf = (r == 32'd0);
        nf = r[31];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one operation and watches 12 cycles after the start edge.
    task automatic run_op(input string tag, input Operation op, input logic [31:0] a, b,
                          input logic c, input logic [31:0] er, input logic ec, ez, en,
                          input bit scramble);
        int done_cycle, done_count, busy_cycles;
        bit drive_ok;
        logic [31:0] res_at_done;
        logic [2:0]  flags_at_done;
        done_cycle = 0; done_count = 0; busy_cycles = 0; drive_ok = 1'b1;
        res_at_done = 'x; flags_at_done = 'x;
        @(negedge clk);
        start = 1'b1; op_in = op; a_in = a; b_in = b; c_in = c;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (scramble && n == 2) begin
                start = 1'b1; a_in = ~a; b_in = a; c_in = ~c; op_in = Operation_XNOR;
            end
            if (scramble && n == 3) start = 1'b0;
            if (busy) busy_cycles++;
            if (n <= BYTES) begin
                if (alu_a !== a[(n-1)*8 +: 8] || alu_b !== b[(n-1)*8 +: 8] || alu_op !== op)
                    drive_ok = 1'b0;
            end
            if (done) begin
                done_count++;
                if (done_cycle == 0) begin
                    done_cycle    = n;
                    res_at_done   = result;
                    flags_at_done = {f_carry, f_zero, f_neg};
                end
            end
        end
        check({tag, " done_cycle"}, 64'(done_cycle), 64'd5);
        check({tag, " done_count"}, 64'(done_count), 64'd1);
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'd5);
        check({tag, " alu_drive"}, 64'(drive_ok), 64'd1);
        check({tag, " result"}, 64'(res_at_done), 64'(er));
        check({tag, " flags_czn"}, 64'(flags_at_done), 64'({ec, ez, en}));
        check({tag, " result_held"}, 64'(result), 64'(er));
        check({tag, " alu_idle"}, 64'({alu_a, alu_b, alu_c, alu_op}), 64'({8'd0, 8'd0, 1'b0, Operation_ADD}));
    endtask

    typedef struct {
        string       name;
        Operation    op;
        logic [31:0] a, b;
        logic        c;
        logic [31:0] er;
        logic        ec, ez, en;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{"add_ff_1",   Operation_ADD,  32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_carry",  Operation_ADD,  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{"sub_borrow", Operation_SUB,  32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"sub_zero",   Operation_SUB,  32'h12345678, 32'h12345677, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{"xor",        Operation_XOR,  32'hA5A5A5A5, 32'hFFFF0000, 1'b1, 32'h5A5AA5A5, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"add_neg",    Operation_ADD,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{"nor",        Operation_NOR,  32'h0F0F0000, 32'h00F00000, 1'b1, 32'hF000FFFF, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{"nand_zero",  Operation_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{"xnor",       Operation_XNOR, 32'h12345678, 32'h12345678, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1};

        rst = 1'b1; start = 1'b0; op_in = Operation_ADD; a_in = '0; b_in = '0; c_in = 1'b0;
        #1;
        check("reset busy_done", 64'({busy, done}), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset flags", 64'({f_carry, f_zero, f_neg}), 64'd0);
        check("reset alu_ports", 64'({alu_a, alu_b, alu_c, alu_op}), 64'({8'd0, 8'd0, 1'b0, Operation_ADD}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c,
                   vecs[i].er, vecs[i].ec, vecs[i].ez, vecs[i].en, 1'b0);

        // A second start plus operand changes during RUN must be ignored.
        run_op("ignore_start", Operation_ADD, 32'h0000FFFF, 32'h00000001, 1'b0,
               32'h00010000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in RUN cycle 3 aborts the operation.
        begin
            int dn;
            dn = 0;
            @(negedge clk);
            start = 1'b1; op_in = Operation_SUB; a_in = 32'h11111111; b_in = 32'h22222222; c_in = 1'b0;
            for (int n = 1; n <= 3; n++) begin
                @(negedge clk);
                if (n == 1) start = 1'b0;
            end
            #2 rst = 1'b1;
            #1;
            check("midrst busy", 64'(busy), 64'd0);
            check("midrst result", 64'(result), 64'd0);
            check("midrst flags", 64'({f_carry, f_zero, f_neg}), 64'd0);
            check("midrst alu_ports", 64'({alu_a, alu_b, alu_c, alu_op}), 64'({8'd0, 8'd0, 1'b0, Operation_ADD}));
            @(negedge clk);
            rst = 1'b0;
            for (int n = 0; n < 8; n++) begin
                @(negedge clk);
                if (done) dn++;
            end
            check("midrst no_done", 64'(dn), 64'd0);
            run_op("after_rst", Operation_SUB, 32'h11111111, 32'h22222222, 1'b0,
                   32'hEEEEEEEF, 1'b1, 1'b0, 1'b1, 1'b0);
        end

        for (int i = 0; i < 40; i++) begin
            Operation    op;
            logic [31:0] a, b, er;
            logic        c, ec, ez, en;
            op = Operation'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       a = 32'h0;
                1:       a = 32'hFFFFFFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = a;
                default: b = $urandom;
            endcase
            c = 1'($urandom_range(0, 1));
            ref_model(op, a, b, c, er, ec, ez, en);
            run_op($sformatf("rand%0d", i), op, a, b, c, er, ec, ez, en, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Multi-byte arithmetic sequencer that drives the 8-bit combinational `alu` to perform ADD, SUB, NOR, NAND, XOR and XNOR on operands `BYTES` bytes wide. It processes the operands one byte per clock, least-significant byte first. Between bytes it chains carry/borrow through the ALU carry input and accumulates the Zero, Neg and Carry flags for the whole word. It sits between the CPU control unit and the ALU, and turns a single start request into a sequence of ALU operations ending with a one-cycle done handshake.

## Interface
Parameters:
- `BYTES`, default 4, operand width in bytes; legal range is 2 to 16.

Ports:
- `_iClk`  in  1  clock; one clock domain.
- `_iReset`  in  1  reset; asynchronous, active-high.
- `_iStart`  in  1  request a new operation; sampled only in IDLE.
- `_iOp`  in  `Operation` (cpu_pkg)  operation to perform.
- `_iA`  in  8*BYTES  operand A.
- `_iB`  in  8*BYTES  operand B.
- `_iC`  in  1  carry-in for ADD, borrow-in for SUB.
- `_oBusy`  out  1  high while in RUN or DONE.
- `_oDone`  out  1  one-cycle pulse; result and flags are valid from this cycle.
- `_oResult`  out  8*BYTES  registered result.
- `_oFlagCarry`  out  1  final carry out of ADD, final borrow out of SUB; 0 for logic ops.
- `_oFlagZero`  out  1  high when all result bytes are zero.
- `_oFlagNeg`  out  1  MSB of the result.
- `_oAluA`, `_oAluB`  out  8  byte operands to the ALU.
- `_oAluC`  out  1  carry to the ALU.
- `_oAluOp`  out  `Operation`  operation to the ALU.
- `_iAluResult`  in  8  ALU result.
- `_iAluFlagCarry`, `_iAluFlagZero`, `_iAluFlagNeg`  in  1 each  ALU flags.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE, with `_iStart` = 1:
  - latch `_iA`, `_iB` and `_iOp`;
  - set carry register to `_iC`, byte index `idx` to 0 and zero accumulator to 1;
  - go to RUN.
- RUN, each cycle:
  - drive `_oAluA` = A byte `idx`, `_oAluB` = B byte `idx`, `_oAluC` = carry register, `_oAluOp` = latched op;
  - capture `_iAluResult` into `_oResult` byte `idx`;
  - carry register <= `_iAluFlagCarry`;
  - zero accumulator <= zero accumulator & `_iAluFlagZero`;
  - `idx` increments.
- RUN, cycle with `idx` = BYTES-1:
  - `_oFlagCarry` <= `_iAluFlagCarry`, `_oFlagNeg` <= `_iAluFlagNeg`, `_oFlagZero` <= updated accumulator;
  - go to DONE.
- DONE: `_oDone` = 1 for exactly one cycle, then go to IDLE unconditionally.
- The sequencer does not decode the op. It relies on ALU semantics:
  - SUB computes a - (b + c) and reports the borrow in carry, so the borrow chains correctly;
  - logic ops report carry 0, so the final carry is 0 regardless of `_iC`.
- In IDLE and DONE the ALU ports are driven as `_oAluA` = 0, `_oAluB` = 0, `_oAluC` = 0, `_oAluOp` = `Operation_ADD`.
- `_oResult` and all flags hold their value until the next accepted start. Bytes are overwritten progressively during the next RUN; they are not valid until `_oDone`.
- `_iStart` in RUN or DONE is ignored; it is not queued.
- Changes to `_iA`, `_iB`, `_iC` or `_iOp` after acceptance have no effect on the operation in progress.

## Timing
- Reset: state IDLE; `_oBusy`, `_oDone`, `_oResult` and all flags are 0; ALU ports at their idle values; `idx` and the carry register are 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset during RUN or DONE: the operation is aborted, `_oDone` never pulses and outputs return to their reset values.
- Latency, with start sampled at edge 0:
  - RUN occupies cycles 1..BYTES;
  - `_oDone` is high in cycle BYTES+1;
  - earliest next start is sampled at the end of cycle BYTES+2 (first IDLE cycle).
- Throughput: one operation per BYTES+2 cycles.
- The ALU is combinational. The sequencer registers every ALU output at the end of each RUN cycle; there is no combinational path from `_iAluResult` to `_oResult`.
- `idx` width is clog2(BYTES). It does not wrap inside RUN; it returns to 0 on the next start.

## Test plan
All scenarios use BYTES = 4.
1. ADD, A = 0x000000FF, B = 0x00000001, C = 0 -> result 0x00000100, Carry 0, Zero 0, Neg 0. `_oDone` in the 5th cycle after the start edge; `_oBusy` high for 5 cycles.
2. ADD, A = 0xFFFFFFFF, B = 0x00000000, C = 1 -> result 0x00000000, Carry 1, Zero 1, Neg 0. Shows carry propagating through every byte.
3. SUB, A = 0x00000000, B = 0x00000001, C = 0 -> result 0xFFFFFFFF, Carry 1, Zero 0, Neg 1.
4. SUB, A = 0x12345678, B = 0x12345677, C = 1 -> result 0x00000000, Carry 0, Zero 1. Then XOR, A = 0xA5A5A5A5, B = 0xFFFF0000, C = 1 -> result 0x5A5AA5A5, Carry 0, Neg 0.
5. Second `_iStart` pulse and operand change in RUN cycle 2 -> ignored: result and flags match the first operation, and only one `_oDone` pulse appears.
6. `_iReset` asserted in RUN cycle 3 -> `_oBusy`, `_oResult` and flags drop to 0 without waiting for a clock edge, and no `_oDone` pulse. A start after reset release completes normally.
